// File: rtl/qerv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// qerv_wb_arbiter
// Shares one Wishbone port between the ibus and dbus, with a bus watchdog.
// Revision: 1.0
// ============================================================================
module qerv_wb_arbiter #(
  parameter int DBUS_PRIO = 1,
  parameter int TIMEOUT   = 255,
  parameter int TW        = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_dbus_q, last_dbus_d;
  logic   gnt_cyc;
  logic   expire;

  // Request line of whichever master currently holds the grant.
  assign gnt_cyc = (state_q == GNT_I) ? i_ibus_cyc :
                   (state_q == GNT_D) ? i_dbus_cyc : 1'b0;

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic [TW-1:0] wdog_q, wdog_d;

      // Expiry lands on the TIMEOUT-th granted cycle; a real ack then wins.
      assign expire = gnt_cyc && !i_wb_ack && (wdog_q == TW'(TIMEOUT - 1));

      always_comb begin
        wdog_d = '0;
        if (gnt_cyc && !i_wb_ack && !expire) begin
          wdog_d = wdog_q + TW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (i_rst) begin
          wdog_q <= '0;
        end else begin
          wdog_q <= wdog_d;
        end
      end
    end else begin : g_no_wdog
      assign expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    last_dbus_d = last_dbus_q;
    o_wb_adr    = '0;
    o_wb_dat    = '0;
    o_wb_sel    = '0;
    o_wb_we     = 1'b0;
    o_wb_cyc    = 1'b0;
    o_ibus_ack  = 1'b0;
    o_ibus_rdt  = '0;
    o_dbus_ack  = 1'b0;
    o_dbus_rdt  = '0;
    o_timeout   = expire;

    case (state_q)
      IDLE: begin
        if (i_dbus_cyc && i_ibus_cyc) begin
          state_d = ((DBUS_PRIO != 0) || !last_dbus_q) ? GNT_D : GNT_I;
        end else if (i_dbus_cyc) begin
          state_d = GNT_D;
        end else if (i_ibus_cyc) begin
          state_d = GNT_I;
        end
      end
      GNT_I: begin
        o_wb_adr   = i_ibus_adr;
        o_wb_sel   = 4'hF;
        o_wb_cyc   = i_ibus_cyc && !expire;
        o_ibus_ack = i_wb_ack || expire;
        o_ibus_rdt = expire ? '0 : i_wb_rdt;
      end
      GNT_D: begin
        o_wb_adr   = i_dbus_adr;
        o_wb_dat   = i_dbus_dat;
        o_wb_sel   = i_dbus_sel;
        o_wb_we    = i_dbus_we;
        o_wb_cyc   = i_dbus_cyc && !expire;
        o_dbus_ack = i_wb_ack || expire;
        o_dbus_rdt = expire ? '0 : i_wb_rdt;
      end
      default: state_d = IDLE;
    endcase

    // Completion (real or synthetic) records the winner; a dropped cyc just aborts.
    if (state_q != IDLE) begin
      if (i_wb_ack || expire) begin
        state_d     = IDLE;
        last_dbus_d = (state_q == GNT_D);
      end else if (!gnt_cyc) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      last_dbus_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dbus_q <= last_dbus_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qerv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_qerv_wb_arbiter
// Scoreboard bench: dut_a (DBUS_PRIO=1, TIMEOUT=8), dut_b (DBUS_PRIO=0, TIMEOUT=4).
// Revision: 1.0
// ============================================================================
module tb_qerv_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic        dbus_we;
  logic        dbus_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        sel_b;

  logic [31:0] a_ibus_rdt, a_dbus_rdt, a_wb_adr, a_wb_dat;
  logic [31:0] b_ibus_rdt, b_dbus_rdt, b_wb_adr, b_wb_dat;
  logic [3:0]  a_wb_sel, b_wb_sel;
  logic        a_ibus_ack, a_dbus_ack, a_wb_we, a_wb_cyc, a_timeout;
  logic        b_ibus_ack, b_dbus_ack, b_wb_we, b_wb_cyc, b_timeout;

  always #5 clk = ~clk;

  qerv_wb_arbiter #(.DBUS_PRIO(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .i_rst(rst),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(a_ibus_rdt), .o_ibus_ack(a_ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(a_dbus_rdt), .o_dbus_ack(a_dbus_ack),
    .o_wb_adr(a_wb_adr), .o_wb_dat(a_wb_dat), .o_wb_sel(a_wb_sel), .o_wb_we(a_wb_we),
    .o_wb_cyc(a_wb_cyc), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_timeout(a_timeout)
  );

  qerv_wb_arbiter #(.DBUS_PRIO(0), .TIMEOUT(4)) dut_b (
    .clk(clk), .i_rst(rst),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(b_ibus_rdt), .o_ibus_ack(b_ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
    .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(b_dbus_rdt), .o_dbus_ack(b_dbus_ack),
    .o_wb_adr(b_wb_adr), .o_wb_dat(b_wb_dat), .o_wb_sel(b_wb_sel), .o_wb_we(b_wb_we),
    .o_wb_cyc(b_wb_cyc), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_timeout(b_timeout)
  );

  // Both DUTs see the same stimulus; sel_b picks the one being scored.
  wire [31:0] m_ibus_rdt = sel_b ? b_ibus_rdt : a_ibus_rdt;
  wire [31:0] m_dbus_rdt = sel_b ? b_dbus_rdt : a_dbus_rdt;
  wire [31:0] m_wb_adr   = sel_b ? b_wb_adr   : a_wb_adr;
  wire [31:0] m_wb_dat   = sel_b ? b_wb_dat   : a_wb_dat;
  wire [3:0]  m_wb_sel   = sel_b ? b_wb_sel   : a_wb_sel;
  wire        m_wb_we    = sel_b ? b_wb_we    : a_wb_we;
  wire        m_wb_cyc   = sel_b ? b_wb_cyc   : a_wb_cyc;
  wire        m_ibus_ack = sel_b ? b_ibus_ack : a_ibus_ack;
  wire        m_dbus_ack = sel_b ? b_dbus_ack : a_dbus_ack;
  wire        m_timeout  = sel_b ? b_timeout  : a_timeout;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          rise;
  } gnt_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdt;
    logic        to;
    int          gc;
  } ack_t;

  gnt_t gq[$];
  ack_t aq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] adr);
    return (adr == 32'h100) ? 32'h0000_0013 : ~adr;
  endfunction

  task automatic exp_gnt(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input int rise);
    gnt_t g;
    g.adr = adr; g.dat = dat; g.sel = sel; g.we = we; g.rise = rise;
    gq.push_back(g);
  endtask

  task automatic exp_ack(input logic is_d, input logic [31:0] rdt, input logic to, input int gc);
    ack_t a;
    a.is_d = is_d; a.rdt = rdt; a.to = to; a.gc = gc;
    aq.push_back(a);
  endtask

  // Monitor: scores every grant rise and every ack/timeout pulse of the selected DUT.
  initial begin : monitor
    logic prev;
    logic in_txn;
    int   gc;
    gnt_t g;
    ack_t a;
    prev   = 1'b0;
    in_txn = 1'b0;
    gc     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_txn = 1'b0;
        prev   = m_wb_cyc;
        continue;
      end
      if (m_ibus_ack || m_dbus_ack || m_timeout) begin
        gc++;
        if (aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ibus_ack=%b dbus_ack=%b timeout=%b, none expected",
                   m_ibus_ack, m_dbus_ack, m_timeout);
        end else begin
          a = aq.pop_front();
          chk("ack_dbus",   32'(m_dbus_ack), 32'(a.is_d));
          chk("ack_ibus",   32'(m_ibus_ack), 32'(!a.is_d));
          chk("ack_rdt",    a.is_d ? m_dbus_rdt : m_ibus_rdt, a.rdt);
          chk("other_rdt",  a.is_d ? m_ibus_rdt : m_dbus_rdt, 32'h0);
          chk("timeout",    32'(m_timeout), 32'(a.to));
          chk("ack_wb_cyc", 32'(m_wb_cyc), 32'(!a.to));
          chk("ack_cycle",  gc, a.gc);
        end
        in_txn = 1'b0;
      end else if (m_wb_cyc && !prev) begin
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: adr=%h, no grant expected", m_wb_adr);
        end else begin
          g = gq.pop_front();
          chk("gnt_adr",   m_wb_adr, g.adr);
          chk("gnt_dat",   m_wb_dat, g.dat);
          chk("gnt_sel",   32'(m_wb_sel), 32'(g.sel));
          chk("gnt_we",    32'(m_wb_we), 32'(g.we));
          chk("gnt_cycle", cyc_no, g.rise);
        end
        in_txn = 1'b1;
        gc     = 1;
      end else if (in_txn && m_wb_cyc) begin
        gc++;
      end else begin
        in_txn = 1'b0;
      end
      prev = m_wb_cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic use_b);
    step();
    rst = 1'b1; sel_b = use_b;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    wb_ack = 1'b0; wb_rdt = 32'hDEAD_BEEF;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_cyc", 32'(m_wb_cyc), 32'h0);
    chk("rst_wb_adr", m_wb_adr, 32'h0);
    chk("rst_ctrl", 32'({m_wb_sel, m_wb_we, m_ibus_ack, m_dbus_ack, m_timeout}), 32'h0);
  endtask

  // Slave + requester driver: acks in grant cycle `lat` (0 = never); drops cyc after ack unless hold.
  task automatic run(input int lat, input int nack, input logic hold);
    int   gcnt;
    int   got;
    int   n;
    logic li;
    logic ld;
    gcnt = 0; got = 0; n = 0; li = 1'b0; ld = 1'b0;
    while (got < nack && n < 80) begin
      step();
      n++;
      if (!hold) begin
        if (li) ibus_cyc = 1'b0;
        if (ld) dbus_cyc = 1'b0;
      end
      wb_ack = (gcnt != 0) && (gcnt + 1 == lat);
      wb_rdt = wb_ack ? slave_data(m_wb_adr) : 32'hDEAD_BEEF;
      @(negedge clk);
      li = m_ibus_ack;
      ld = m_dbus_ack;
      if (li || ld) begin
        got++;
        gcnt = 0;
      end else if (m_wb_cyc) begin
        gcnt++;
      end else begin
        gcnt = 0;
      end
    end
    if (got < nack) chk("run_budget", got, nack);
    step();
    wb_ack = 1'b0;
    wb_rdt = 32'hDEAD_BEEF;
    if (!hold) begin
      if (li) ibus_cyc = 1'b0;
      if (ld) dbus_cyc = 1'b0;
    end
  endtask

  initial begin : stim
    int n;
    rst = 1'b1; sel_b = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    wb_ack = 1'b0; wb_rdt = 32'hDEAD_BEEF;

    // ibus fetch alone, slave acks in third grant cycle
    reset_dut(1'b0);
    step(); n = cyc_no;
    ibus_adr = 32'h100; ibus_cyc = 1'b1;
    exp_gnt(32'h100, 32'h0, 4'hF, 1'b0, n + 1);
    exp_ack(1'b0, 32'h13, 1'b0, 3);
    run(3, 1, 1'b0);

    // simultaneous requests, dbus priority, one bubble before ibus
    reset_dut(1'b0);
    step(); n = cyc_no;
    dbus_adr = 32'h2000; dbus_dat = 32'hAABB; dbus_sel = 4'h3; dbus_we = 1'b1; dbus_cyc = 1'b1;
    ibus_adr = 32'h104; ibus_cyc = 1'b1;
    exp_gnt(32'h2000, 32'hAABB, 4'h3, 1'b1, n + 1);
    exp_gnt(32'h104, 32'h0, 4'hF, 1'b0, n + 4);
    exp_ack(1'b1, ~32'h2000, 1'b0, 2);
    exp_ack(1'b0, ~32'h104, 1'b0, 2);
    run(2, 2, 1'b0);

    // round robin with both requests held
    reset_dut(1'b1);
    step(); n = cyc_no;
    dbus_adr = 32'h3000; dbus_dat = 32'h0; dbus_sel = 4'hF; dbus_we = 1'b0; dbus_cyc = 1'b1;
    ibus_adr = 32'h200; ibus_cyc = 1'b1;
    exp_gnt(32'h3000, 32'h0, 4'hF, 1'b0, n + 1);
    exp_gnt(32'h200,  32'h0, 4'hF, 1'b0, n + 4);
    exp_gnt(32'h3000, 32'h0, 4'hF, 1'b0, n + 7);
    exp_gnt(32'h200,  32'h0, 4'hF, 1'b0, n + 10);
    exp_ack(1'b1, ~32'h3000, 1'b0, 2);
    exp_ack(1'b0, ~32'h200,  1'b0, 2);
    exp_ack(1'b1, ~32'h3000, 1'b0, 2);
    exp_ack(1'b0, ~32'h200,  1'b0, 2);
    run(2, 4, 1'b1);
    ibus_cyc = 1'b0; dbus_cyc = 1'b0;

    // watchdog expiry on a dbus read, TIMEOUT=8
    reset_dut(1'b0);
    step(); n = cyc_no;
    dbus_adr = 32'h4000; dbus_dat = 32'h0; dbus_sel = 4'hF; dbus_we = 1'b0; dbus_cyc = 1'b1;
    exp_gnt(32'h4000, 32'h0, 4'hF, 1'b0, n + 1);
    exp_ack(1'b1, 32'h0, 1'b1, 8);
    run(0, 1, 1'b0);

    // reset mid-grant aborts; stray ack in IDLE is ignored
    reset_dut(1'b0);
    step(); n = cyc_no;
    dbus_adr = 32'h5000; dbus_sel = 4'hF; dbus_we = 1'b0; dbus_cyc = 1'b1;
    exp_gnt(32'h5000, 32'h0, 4'hF, 1'b0, n + 1);
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("rst_abort_wb_cyc", 32'(m_wb_cyc), 32'h0);
    chk("rst_abort_ack", 32'({m_ibus_ack, m_dbus_ack, m_timeout}), 32'h0);
    step();
    rst = 1'b0; dbus_cyc = 1'b0; wb_ack = 1'b1; wb_rdt = 32'h99;
    @(negedge clk);
    chk("stray_ack", 32'({m_ibus_ack, m_dbus_ack, m_timeout}), 32'h0);
    chk("stray_wb_cyc", 32'(m_wb_cyc), 32'h0);
    step();
    wb_ack = 1'b0; wb_rdt = 32'hDEAD_BEEF;

    // requester drops cyc mid-grant: abort, then a fresh dbus request is granted
    reset_dut(1'b0);
    step(); n = cyc_no;
    ibus_adr = 32'h140; ibus_cyc = 1'b1;
    exp_gnt(32'h140, 32'h0, 4'hF, 1'b0, n + 1);
    step();
    step();
    step();
    ibus_cyc = 1'b0;
    @(negedge clk);
    chk("drop_wb_cyc", 32'(m_wb_cyc), 32'h0);
    chk("drop_no_ack", 32'({m_ibus_ack, m_dbus_ack, m_timeout}), 32'h0);
    step(); n = cyc_no;
    dbus_adr = 32'h6000; dbus_dat = 32'hCAFE_F00D; dbus_sel = 4'h5; dbus_we = 1'b1; dbus_cyc = 1'b1;
    exp_gnt(32'h6000, 32'hCAFE_F00D, 4'h5, 1'b1, n + 1);
    exp_ack(1'b1, ~32'h6000, 1'b0, 2);
    run(2, 1, 1'b0);

    // real ack on the expiry cycle wins, TIMEOUT=4
    reset_dut(1'b1);
    step(); n = cyc_no;
    dbus_adr = 32'h7000; dbus_dat = 32'h1234_5678; dbus_sel = 4'hC; dbus_we = 1'b1; dbus_cyc = 1'b1;
    exp_gnt(32'h7000, 32'h1234_5678, 4'hC, 1'b1, n + 1);
    exp_ack(1'b1, ~32'h7000, 1'b0, 4);
    run(4, 1, 1'b0);

    // ibus watchdog expiry, TIMEOUT=4
    reset_dut(1'b1);
    step(); n = cyc_no;
    ibus_adr = 32'h300; ibus_cyc = 1'b1;
    exp_gnt(32'h300, 32'h0, 4'hF, 1'b0, n + 1);
    exp_ack(1'b0, 32'h0, 1'b1, 4);
    run(0, 1, 1'b0);

    step();
    step();
    chk("gnt_queue_empty", gq.size(), 32'h0);
    chk("ack_queue_empty", aq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
